// File: rtl/commit_out_tx_pkg.sv
// Shared types and constants for the commit-ordered UART output path.
package commit_out_tx_pkg;

  // 100 MHz clock, 115200 baud.
  localparam int DEFAULT_CLK_PER_BIT = 868;

  // Bit-period counter width; covers CLK_PER_BIT up to 65535.
  localparam int BIT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/commit_out_tx_if.sv
// Exec/commit/flush handshake bundle between the pipeline and the output buffer.
interface commit_out_tx_if;

  logic       flush;
  logic       exec_valid;
  logic [7:0] exec_data;
  logic       exec_ready;
  logic       commit_valid;
  logic       commit_ready;

  // Pipeline side: produces bytes, commits and flushes.
  modport master (
    output flush, exec_valid, exec_data, commit_valid,
    input  exec_ready, commit_ready
  );

  // Buffer side.
  modport slave (
    input  flush, exec_valid, exec_data, commit_valid,
    output exec_ready, commit_ready
  );

endinterface

// File: rtl/commit_out_tx_uart_tx.sv
// 8N1 UART transmitter: accepts one byte in IDLE and shifts it out LSB first.
module uart_tx
  import commit_out_tx_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(CLK_PER_BIT - 1);

  tx_state_t            state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 cnt_done;

  assign cnt_done = (cnt_q == CNT_LAST);
  assign ready    = (state_q == IDLE);
  assign txd      = txd_q;

  // Next-state, bit timing and the registered line level for the next cycle.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          shift_d = data;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level follows the state being entered, so txd comes straight off a flop.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // State, counters, shift register and line flop.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values and updates together.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/commit_out_tx.sv
// Speculative output buffer: bytes are written in program order, released on
// commit, discarded on flush, and committed bytes are serialised over UART.
module commit_out_tx
  import commit_out_tx_pkg::*;
#(
  parameter int CLK_PER_BIT   = DEFAULT_CLK_PER_BIT,
  parameter int OUT_BUF_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  commit_out_tx_if.slave       bus,
  output logic                 txd,
  output logic                 busy
);

  localparam int DEPTH = 2 ** OUT_BUF_WIDTH;

  typedef logic [OUT_BUF_WIDTH-1:0] ptr_t;

  // tx_ptr..commit_ptr-1 is committed, commit_ptr..write_ptr-1 is speculative.
  ptr_t       tx_ptr_q, tx_ptr_d;
  ptr_t       commit_ptr_q, commit_ptr_d;
  ptr_t       write_ptr_q, write_ptr_d;
  logic [7:0] mem_q [DEPTH];

  logic exec_hs;
  logic commit_hs;
  logic mem_we;
  logic tx_valid;
  logic tx_ready;
  logic tx_pop;

  // One slot is kept empty so full and empty are distinguishable.
  assign bus.exec_ready   = (write_ptr_q + ptr_t'(1)) != tx_ptr_q;
  assign bus.commit_ready = commit_ptr_q != write_ptr_q;

  assign exec_hs   = bus.exec_valid && bus.exec_ready;
  assign commit_hs = bus.commit_valid && bus.commit_ready;
  assign mem_we    = exec_hs && !bus.flush && !reset;

  assign tx_valid = tx_ptr_q != commit_ptr_q;
  assign tx_pop   = tx_valid && tx_ready;
  assign busy     = tx_valid || !tx_ready;

  // Pointer advance; flush rewinds write_ptr to the post-commit boundary.
  always_comb begin
    tx_ptr_d     = tx_ptr_q;
    commit_ptr_d = commit_ptr_q;
    write_ptr_d  = write_ptr_q;
    if (tx_pop) begin
      tx_ptr_d = tx_ptr_q + ptr_t'(1);
    end
    if (commit_hs) begin
      commit_ptr_d = commit_ptr_q + ptr_t'(1);
    end
    if (bus.flush) begin
      write_ptr_d = commit_ptr_d;
    end else if (exec_hs) begin
      write_ptr_d = write_ptr_q + ptr_t'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ptr_q     <= '0;
      commit_ptr_q <= '0;
      write_ptr_q  <= '0;
    end else begin
      tx_ptr_q     <= tx_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      write_ptr_q  <= write_ptr_d;
    end
  end

  // Byte storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone define which entries hold valid bytes.
    if (mem_we) begin
      mem_q[write_ptr_q] <= bus.exec_data;
    end
  end

  uart_tx #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .reset (reset),
    .valid (tx_valid),
    .data  (mem_q[tx_ptr_q]),
    .ready (tx_ready),
    .txd   (txd)
  );

endmodule

// File: tb/tb_commit_out_tx.sv
// Scoreboard bench: committed bytes are queued as expected frames and a UART
// receiver model decodes txd and compares each frame against the queue.
module tb_commit_out_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;
  logic txd;
  logic busy;

  commit_out_tx_if bus ();

  commit_out_tx #(
    .CLK_PER_BIT  (CPB),
    .OUT_BUF_WIDTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave),
    .txd  (txd),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] spec_q [$];   // model of the speculative region
  logic [7:0] exp_q  [$];   // committed bytes awaiting a frame on txd
  int         start_cyc [$];

  int         cyc = 0;
  bit         mon_active = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART receiver: samples mid-bit on the falling clock edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active = 1;
        mon_cnt    = 0;
        mon_byte   = '0;
        start_cyc.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) begin
        check("rx_start_bit", 32'(txd), 32'd0);
      end else if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0) begin
        mon_byte[(mon_cnt - 6) / 4] = txd;
      end else if (mon_cnt == 38) begin
        check("rx_stop_bit", 32'(txd), 32'd1);
        check("rx_frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("rx_byte", 32'(mon_byte), 32'(mon_exp));
        end
      end else if (mon_cnt == 40) begin
        check("rx_idle_after_stop", 32'(txd), 32'd1);
        mon_active = 0;
      end
    end
  end

  // One clock cycle of stimulus plus model update; called just after a rising edge.
  task automatic cycle(input bit ev, input logic [7:0] ed, input bit cv, input bit fl,
                       input int exp_er = -1);
    int er;
    bit ehs;
    bit chs;
    bus.exec_valid   = ev;
    bus.exec_data    = ed;
    bus.commit_valid = cv;
    bus.flush        = fl;
    er = (exp_er >= 0) ? exp_er : (ev ? 1 : -1);
    @(negedge clk);
    check("commit_ready", 32'(bus.commit_ready), 32'(spec_q.size() != 0));
    if (er >= 0) check("exec_ready", 32'(bus.exec_ready), 32'(er));
    ehs = ev && (er == 1);
    chs = cv && (spec_q.size() != 0);
    @(posedge clk);
    if (chs) exp_q.push_back(spec_q.pop_front());
    if (fl) spec_q.delete();
    else if (ehs) spec_q.push_back(ed);
    #1;
    bus.exec_valid   = 1'b0;
    bus.commit_valid = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset            = 1'b1;
    bus.exec_valid   = 1'b0;
    bus.exec_data    = 8'h00;
    bus.commit_valid = 1'b0;
    bus.flush        = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    spec_q.delete();
    exp_q.delete();
  endtask

  task automatic post_reset_checks(input string tag);
    @(negedge clk);
    check({tag, "_txd"},          32'(txd), 32'd1);
    check({tag, "_exec_ready"},   32'(bus.exec_ready), 32'd1);
    check({tag, "_commit_ready"}, 32'(bus.commit_ready), 32'd0);
    check({tag, "_busy"},         32'(busy), 32'd0);
    check({tag, "_tx_ptr"},       32'(dut.tx_ptr_q), 32'd0);
    check({tag, "_commit_ptr"},   32'(dut.commit_ptr_q), 32'd0);
    check({tag, "_write_ptr"},    32'(dut.write_ptr_q), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Cycle-exact line check of one frame, starting at the first start-bit cycle.
  task automatic frame_exact(input logic [7:0] b);
    logic [9:0] pat;
    pat = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      check("t1_txd", 32'(txd), 32'(pat[i / CPB]));
      check("t1_busy_in_frame", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  // Wait until every committed byte has been received and the line is quiet.
  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_drain_in_time"}, 32'(n < 2000), 32'd1);
    idle(3);
    check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    post_reset_checks("reset");

    // 0x41 executed then committed; exact line waveform and latency.
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_txd_load_cycle", 32'(txd), 32'd1);
    check("t1_busy_load_cycle", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    frame_exact(8'h41);
    @(negedge clk);
    check("t1_busy_after_stop", 32'(busy), 32'd0);
    check("t1_txd_after_stop", 32'(txd), 32'd1);
    @(posedge clk);
    #1;
    drain("t1");

    // Flush without commit discards everything speculative.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t2_txd_quiet", 32'(txd), 32'd1);
      check("t2_busy_quiet", 32'(busy), 32'd0);
      check("t2_commit_ready", 32'(bus.commit_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    drain("t2");

    // Commit with same-cycle flush and exec: committed byte survives, exec dropped.
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 1'b1, 1'b1);
    idle(2);
    drain("t3");

    // Exec, commit, TX pop and flush all in one cycle.
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b1, 1'b0);
    cycle(1'b1, 8'h03, 1'b1, 1'b1);
    idle(1);
    drain("t_mix");

    // Exec and commit_valid together: no bypass, handshake lands next cycle.
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("t6_busy_after_commit", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    drain("t6");

    // Fill all 15 slots, confirm full, then commit everything back to back.
    start_cyc.delete();
    for (int i = 0; i < 15; i++) cycle(1'b1, 8'(8'h80 + i * 7), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    drain("t4");
    check("t4_frame_count", 32'(start_cyc.size()), 32'd15);
    for (int i = 1; i < start_cyc.size(); i++) begin
      check("t4_frame_spacing", 32'(start_cyc[i] - start_cyc[i-1]), 32'(10 * CPB + 1));
    end

    // Reset in the middle of data bit 3 of 0xC3 (bit 3 is 0).
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle(18);
    reset = 1'b1;
    @(negedge clk);
    check("t5_txd_bit3_before_reset", 32'(txd), 32'd0);
    check("t5_busy_before_reset", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    spec_q.delete();
    exp_q.delete();
    post_reset_checks("t5");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("t5_txd_stays_idle", 32'(txd), 32'd1);
      @(posedge clk);
      #1;
    end

    // Buffer still usable after the abort.
    cycle(1'b1, 8'h7E, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    drain("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
